// File: rtl/hex_line_pkg.sv
// Shared constants for the hex line receiver: ASCII codes, FSM encoding and
// the character classifier used by the decode FSM.
package hex_line_pkg;

    localparam logic [7:0] CH_SP     = 8'h20;
    localparam logic [7:0] CH_CR     = 8'h0D;
    localparam logic [7:0] CH_LF     = 8'h0A;
    localparam logic [7:0] CH_PROMPT = 8'h3E;

    localparam logic [1:0] S_HI   = 2'd0;
    localparam logic [1:0] S_LO   = 2'd1;
    localparam logic [1:0] S_OUT  = 2'd2;
    localparam logic [1:0] S_SKIP = 2'd3;

    typedef enum logic [2:0] {
        CC_HEX,
        CC_WS,
        CC_CR,
        CC_PROMPT,
        CC_BAD
    } char_cls_e;

    function automatic char_cls_e classify(input logic [7:0] ch, input logic is_hex);
        if (is_hex) return CC_HEX;
        case (ch)
            CH_SP, CH_LF: return CC_WS;
            CH_CR:        return CC_CR;
            CH_PROMPT:    return CC_PROMPT;
            default:      return CC_BAD;
        endcase
    endfunction

endpackage

// File: rtl/hex_line_rx_if.sv
// UART RX FIFO read side plus decoded byte stream; slave = receiver side.
interface hex_line_rx_if #(
    parameter int DBIT = 8
);
    logic            rx_empty;
    logic [DBIT-1:0] r_data;
    logic            rd_uart;
    logic [7:0]      out_data;
    logic            out_valid;
    logic            out_ready;

    modport slave (
        input  rx_empty, r_data, out_ready,
        output rd_uart, out_data, out_valid
    );

    modport master (
        output rx_empty, r_data, out_ready,
        input  rd_uart, out_data, out_valid
    );
endinterface

// File: rtl/hex_line_rx_ascii_hex_decode.sv
// Combinational ASCII hex digit decoder (0-9, A-F, a-f).
module ascii_hex_decode (
    input  logic [7:0] char_i,
    output logic       is_hex_o,
    output logic [3:0] nibble_o
);
    always_comb begin
        is_hex_o = 1'b0;
        nibble_o = 4'h0;
        if (char_i inside {[8'h30:8'h39]}) begin
            is_hex_o = 1'b1;
            nibble_o = char_i[3:0];
        end else if (char_i inside {[8'h41:8'h46], [8'h61:8'h66]}) begin
            // 'A'/'a' have low nibble 1, so +9 maps them onto 10..15
            is_hex_o = 1'b1;
            nibble_o = char_i[3:0] + 4'd9;
        end
    end
endmodule

// File: rtl/hex_line_rx.sv
// Decodes space-separated ASCII hex pairs from the UART RX FIFO into a byte stream.
// Optional inter-character timeout enabled by macro HEX_LINE_TIMEOUT_EN.
//
// state  | meaning
// S_HI   | waiting for high nibble (or SP/LF/CR/'>')
// S_LO   | high nibble latched, waiting for low nibble
// S_OUT  | decoded byte offered downstream, no pops
// S_SKIP | discarding a broken line until CR or '>'
module hex_line_rx
    import hex_line_pkg::*;
#(
    parameter int DBIT      = 8,
    parameter int LEN_W     = 8,
    parameter int MAX_LEN   = 64,
    parameter int TO_CYCLES = 1000000
) (
    input  logic             clk,
    input  logic             reset,
    hex_line_rx_if.slave     bus,
    output logic             line_done,
    output logic [LEN_W-1:0] line_len,
    output logic             prompt,
    output logic             err
);
    if (DBIT < 8 || MAX_LEN < 1 || MAX_LEN >= (1 << LEN_W) || TO_CYCLES < 2) begin : g_param_check
        $error("hex_line_rx: unsupported parameter combination");
    end

    logic [1:0]       state_q, state_d;
    logic [3:0]       hi_q, hi_d;
    logic [LEN_W-1:0] count_q, count_d;
    logic [LEN_W-1:0] line_len_q, line_len_d;
    logic [7:0]       data_q, data_d;
    logic             valid_q, valid_d;
    logic             line_done_q, line_done_d;
    logic             prompt_q, prompt_d;
    logic             err_q, err_d;

    logic [DBIT-1:0]  raw_char;
    logic [7:0]       ch;
    logic             is_hex;
    logic [3:0]       nib;
    char_cls_e        cls;
    logic             rd;
    logic             handshake;
    logic             line_full;

    assign raw_char = bus.r_data;
    assign ch       = raw_char[7:0];

    ascii_hex_decode u_dec (
        .char_i   (ch),
        .is_hex_o (is_hex),
        .nibble_o (nib)
    );

    assign cls       = classify(ch, is_hex);
    assign rd        = reset && !bus.rx_empty && (state_q != S_OUT);
    assign handshake = valid_q && bus.out_ready;
    // The byte that brings the line up to MAX_LEN ends it as an overflow
    assign line_full = (count_q == LEN_W'(MAX_LEN - 1));

`ifdef HEX_LINE_TIMEOUT_EN
    localparam int TO_W = $clog2(TO_CYCLES);
    logic [TO_W-1:0] to_cnt_q, to_cnt_d;
    logic            to_active;
    logic            to_hit;

    assign to_active = (state_q != S_HI) || (count_q != '0);
    assign to_hit    = to_active && !rd && (to_cnt_q == TO_W'(TO_CYCLES - 1));

    always_comb begin
        to_cnt_d = to_cnt_q + TO_W'(1);
        if (rd || to_hit || !to_active) to_cnt_d = '0;
    end

    always_ff @(posedge clk) begin
        if (!reset) to_cnt_q <= '0;
        else        to_cnt_q <= to_cnt_d;
    end
`endif

    always_comb begin
        state_d     = state_q;
        hi_d        = hi_q;
        count_d     = count_q;
        line_len_d  = line_len_q;
        data_d      = data_q;
        valid_d     = valid_q;
        line_done_d = 1'b0;
        prompt_d    = 1'b0;
        err_d       = 1'b0;

        case (state_q)
            S_HI: if (rd) begin
                case (cls)
                    CC_HEX: begin
                        hi_d    = nib;
                        state_d = S_LO;
                    end
                    CC_CR: if (count_q != '0) begin
                        line_done_d = 1'b1;
                        line_len_d  = count_q;
                        count_d     = '0;
                    end
                    CC_PROMPT: begin
                        prompt_d = 1'b1;
                        count_d  = '0;
                    end
                    CC_BAD: begin
                        err_d   = 1'b1;
                        state_d = S_SKIP;
                    end
                    default: ;
                endcase
            end
            S_LO: if (rd) begin
                case (cls)
                    CC_HEX: begin
                        data_d  = {hi_q, nib};
                        valid_d = 1'b1;
                        state_d = S_OUT;
                    end
                    CC_CR: begin
                        err_d   = 1'b1;
                        count_d = '0;
                        state_d = S_HI;
                    end
                    default: begin
                        err_d   = 1'b1;
                        state_d = S_SKIP;
                    end
                endcase
            end
            S_OUT: if (handshake) begin
                valid_d = 1'b0;
                count_d = count_q + LEN_W'(1);
                if (line_full) begin
                    err_d   = 1'b1;
                    state_d = S_SKIP;
                end else begin
                    state_d = S_HI;
                end
            end
            S_SKIP: if (rd) begin
                if (cls == CC_CR) begin
                    count_d = '0;
                    state_d = S_HI;
                end else if (cls == CC_PROMPT) begin
                    prompt_d = 1'b1;
                    count_d  = '0;
                    state_d  = S_HI;
                end
            end
            default: state_d = S_HI;
        endcase

`ifdef HEX_LINE_TIMEOUT_EN
        if (to_hit) begin
            err_d       = 1'b1;
            count_d     = '0;
            valid_d     = 1'b0;
            line_done_d = 1'b0;
            prompt_d    = 1'b0;
            state_d     = S_HI;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= S_HI;
            hi_q        <= '0;
            count_q     <= '0;
            line_len_q  <= '0;
            data_q      <= '0;
            valid_q     <= 1'b0;
            line_done_q <= 1'b0;
            prompt_q    <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            hi_q        <= hi_d;
            count_q     <= count_d;
            line_len_q  <= line_len_d;
            data_q      <= data_d;
            valid_q     <= valid_d;
            line_done_q <= line_done_d;
            prompt_q    <= prompt_d;
            err_q       <= err_d;
        end
    end

    assign bus.rd_uart   = rd;
    assign bus.out_data  = data_q;
    assign bus.out_valid = valid_q;
    assign line_done     = line_done_q;
    assign line_len      = line_len_q;
    assign prompt        = prompt_q;
    assign err           = err_q;

endmodule
